// File: rtl/alu_issue_ctrl.sv
// Issue/collect sequencer for a fixed-latency 32-bit ALU: one request in flight,
// operands held for ALU_LAT cycles, results returned over a valid/ready channel.
module alu_issue_ctrl #(
  parameter int ALU_LAT = 1,
  parameter int WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [5:0]       instr_op,
  input  logic [WIDTH-1:0] instr_a,
  input  logic [WIDTH-1:0] instr_b,
  input  logic             instr_cin,
  input  logic             instr_use_cf,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [5:0]       alu_opcode,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_ans,
  input  logic             alu_ans_opt,
  input  logic             alu_z,
  input  logic             alu_n,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_opt,
  output logic             res_z,
  output logic             res_n,
  output logic             res_err,
  output logic             carry_flag
);

  // Both channels are strict valid/ready: a transfer happens on a rising edge
  // where valid && ready; valid never depends on ready, and a producer holding
  // valid keeps its payload stable until the transfer.

  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;
  localparam logic [3:0] LAT_INIT = 4'(ALU_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [5:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             opt_q, opt_d;
  logic             z_q, z_d;
  logic             n_q, n_d;
  logic             err_q, err_d;
  logic             cf_q, cf_d;
  logic             op_legal;
  logic             op_q_arith;

  assign op_legal   = (instr_op == OP_ADD) || (instr_op == OP_SUB) || (instr_op == OP_EQ);
  assign op_q_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    data_d  = data_q;
    opt_d   = opt_q;
    z_d     = z_q;
    n_d     = n_q;
    err_d   = err_q;
    cf_d    = cf_q;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d  = instr_op;
          a_d   = instr_a;
          b_d   = instr_b;
          cin_d = instr_use_cf ? cf_q : instr_cin;
          if (op_legal) begin
            state_d = ST_EXEC;
            cnt_d   = LAT_INIT;
          end else begin
            // Illegal opcodes never reach the ALU; answer with an error result.
            state_d = ST_RESP;
            data_d  = '0;
            opt_d   = 1'b0;
            z_d     = 1'b0;
            n_d     = 1'b0;
            err_d   = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_RESP;
          data_d  = alu_ans;
          opt_d   = alu_ans_opt;
          z_d     = alu_z;
          n_d     = alu_n;
          err_d   = 1'b0;
          // Only add/subtract produce a carry/borrow; equality's bit is relational.
          if (op_q_arith) cf_d = alu_ans_opt;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: begin
        if (res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      data_q  <= '0;
      opt_q   <= 1'b0;
      z_q     <= 1'b0;
      n_q     <= 1'b0;
      err_q   <= 1'b0;
      cf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      data_q  <= data_d;
      opt_q   <= opt_d;
      z_q     <= z_d;
      n_q     <= n_d;
      err_q   <= err_d;
      cf_q    <= cf_d;
    end
  end

  // ALU inputs come from latched operands only and are zero outside EXEC.
  always_comb begin
    alu_a      = '0;
    alu_b      = '0;
    alu_opcode = '0;
    alu_cin    = 1'b0;
    if (state_q == ST_EXEC) begin
      alu_a      = a_q;
      alu_b      = b_q;
      alu_opcode = op_q;
      alu_cin    = cin_q;
    end
  end

  assign instr_ready = (state_q == ST_IDLE);
  assign res_valid   = (state_q == ST_RESP);
  assign res_data    = data_q;
  assign res_opt     = opt_q;
  assign res_z       = z_q;
  assign res_n       = n_q;
  assign res_err     = err_q;
  assign carry_flag  = cf_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: two instances (ALU_LAT=1 and 3) share stimulus, each
// with a behavioural ALU and its own expected-result queue.
module tb_alu_issue_ctrl;

  localparam int W  = 32;
  localparam int EW = 16 + 5 + W;  // {due_cycle, carry_flag, err, n, z, opt, data}
  localparam logic [5:0] OP_ADD = 6'b010000;
  localparam logic [5:0] OP_SUB = 6'b010001;
  localparam logic [5:0] OP_EQ  = 6'b100000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          instr_valid;
  logic [5:0]    instr_op;
  logic [W-1:0]  instr_a, instr_b;
  logic          instr_cin, instr_use_cf;
  logic          res_ready;
  logic          exp_cf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // Returns {carry/borrow or relational bit, ans}
  function automatic logic [W:0] alu_ref(input logic [5:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic cin);
    logic [W:0] r;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      OP_SUB:  r = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, cin};
      OP_EQ:   r = {(a == b), a ^ b};
      default: r = '0;
    endcase
    return r;
  endfunction

  // ---------------- DUTs, ALU models, monitors ----------------
  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : 3;
    logic          instr_ready;
    logic [W-1:0]  alu_a, alu_b, alu_ans, res_data;
    logic [5:0]    alu_opcode;
    logic          alu_cin, alu_ans_opt, alu_z, alu_n;
    logic          res_valid, res_opt, res_z, res_n, res_err, carry_flag;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] cur;
    logic [W+3:0]  seen_val;
    logic [6+2*W:0] hold_ref;
    bit            seen = 0;
    int            hold = 0;

    assign {alu_ans_opt, alu_ans} = alu_ref(alu_opcode, alu_a, alu_b, alu_cin);
    assign alu_z = (alu_ans == '0);
    assign alu_n = alu_ans[W-1];

    alu_issue_ctrl #(.ALU_LAT(LAT), .WIDTH(W)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
      .instr_a(instr_a), .instr_b(instr_b), .instr_cin(instr_cin), .instr_use_cf(instr_use_cf),
      .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode), .alu_cin(alu_cin),
      .alu_ans(alu_ans), .alu_ans_opt(alu_ans_opt), .alu_z(alu_z), .alu_n(alu_n),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_opt(res_opt), .res_z(res_z), .res_n(res_n), .res_err(res_err),
      .carry_flag(carry_flag)
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        seen = 0;
        hold = 0;
      end else begin
        // ALU inputs: stable while issued, issued for exactly LAT cycles
        if (alu_opcode != 6'd0) begin
          if (hold == 0) hold_ref = {alu_opcode, alu_a, alu_b, alu_cin};
          else check($sformatf("alu_stable_L%0d", LAT),
                     64'({alu_opcode, alu_a, alu_b, alu_cin} == hold_ref), 64'd1);
          hold++;
        end else if (hold != 0) begin
          check($sformatf("alu_hold_len_L%0d", LAT), 64'(hold), 64'(LAT));
          hold = 0;
        end
        // result scoreboard
        if (res_valid && !seen) begin
          if (exp_q.size() == 0) begin
            check($sformatf("unexpected_res_L%0d", LAT), 64'(exp_q.size()), 64'd1);
          end else begin
            cur = exp_q.pop_front();
            check($sformatf("res_time_L%0d", LAT), 64'(cyc), 64'(cur[EW-1 -: 16]));
            check($sformatf("res_data_L%0d", LAT), 64'(res_data), 64'(cur[W-1:0]));
            check($sformatf("res_err_n_z_opt_L%0d", LAT),
                  64'({res_err, res_n, res_z, res_opt}), 64'(cur[W+3:W]));
            check($sformatf("carry_flag_L%0d", LAT), 64'(carry_flag), 64'(cur[W+4]));
          end
          seen     = 1;
          seen_val = {res_err, res_n, res_z, res_opt, res_data};
        end else if (res_valid && seen) begin
          check($sformatf("res_stable_L%0d", LAT),
                64'({res_err, res_n, res_z, res_opt, res_data} == seen_val), 64'd1);
        end
        if (res_valid && res_ready) seen = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [5:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic cin, input logic use_cf);
    int          guard;
    logic        c;
    logic        legal;
    logic [W:0]  r;
    logic [4:0]  flags;  // {cf, err, n, z, opt}
    logic [15:0] k;
    guard = 0;
    @(negedge clk);
    while (!(g_dut[0].instr_ready && g_dut[1].instr_ready) && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) begin
      check("ready_timeout", 64'({g_dut[0].instr_ready, g_dut[1].instr_ready}), 64'd3);
      return;
    end
    instr_op     = op;
    instr_a      = a;
    instr_b      = b;
    instr_cin    = cin;
    instr_use_cf = use_cf;
    instr_valid  = 1'b1;
    c     = use_cf ? exp_cf : cin;
    legal = (op == OP_ADD) || (op == OP_SUB) || (op == OP_EQ);
    k     = 16'(cyc + 1);
    if (legal) begin
      r = alu_ref(op, a, b, c);
      if (op != OP_EQ) exp_cf = r[W];
      flags = {exp_cf, 1'b0, r[W-1], (r[W-1:0] == '0), r[W]};
      g_dut[0].exp_q.push_back({16'(k + 16'd1), flags, r[W-1:0]});
      g_dut[1].exp_q.push_back({16'(k + 16'd3), flags, r[W-1:0]});
    end else begin
      flags = {exp_cf, 1'b1, 3'b000};
      g_dut[0].exp_q.push_back({k, flags, {W{1'b0}}});
      g_dut[1].exp_q.push_back({k, flags, {W{1'b0}}});
    end
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    // request fields need not be held after the accept
    instr_op = 6'($urandom);
    instr_a  = $urandom;
    instr_b  = $urandom;
    instr_cin = 1'($urandom);
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < 2; d++) begin
      logic [3:0] rv;
      logic [W-1:0] rd;
      logic [5:0] op;
      logic [2*W:0] ab;
      logic cf;
      if (d == 0) begin
        rv = {g_dut[0].instr_ready, g_dut[0].res_valid, g_dut[0].res_err, g_dut[0].res_opt};
        rd = g_dut[0].res_data; op = g_dut[0].alu_opcode; cf = g_dut[0].carry_flag;
        ab = {g_dut[0].alu_a, g_dut[0].alu_b, g_dut[0].alu_cin};
      end else begin
        rv = {g_dut[1].instr_ready, g_dut[1].res_valid, g_dut[1].res_err, g_dut[1].res_opt};
        rd = g_dut[1].res_data; op = g_dut[1].alu_opcode; cf = g_dut[1].carry_flag;
        ab = {g_dut[1].alu_a, g_dut[1].alu_b, g_dut[1].alu_cin};
      end
      check($sformatf("%s_rdy_vld_err_opt_%0d", tag, d), 64'(rv), 64'b1000);
      check($sformatf("%s_res_data_%0d", tag, d), 64'(rd), 64'd0);
      check($sformatf("%s_alu_opcode_%0d", tag, d), 64'(op), 64'd0);
      check($sformatf("%s_alu_ab_zero_%0d", tag, d), 64'(ab == '0), 64'd1);
      check($sformatf("%s_carry_flag_%0d", tag, d), 64'(cf), 64'd0);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    logic [5:0] rop;
    instr_valid = 1'b0; instr_op = '0; instr_a = '0; instr_b = '0;
    instr_cin = 1'b0; instr_use_cf = 1'b0; res_ready = 1'b1; exp_cf = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    send(OP_ADD, 32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0);
    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(OP_ADD, 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1);
    @(negedge clk);
    check("use_cf_alu_cin_L1", 64'(g_dut[0].alu_cin), 64'd1);
    check("use_cf_alu_cin_L3", 64'(g_dut[1].alu_cin), 64'd1);

    send(6'b111111, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("illegal_no_issue", 64'({g_dut[0].alu_opcode, g_dut[1].alu_opcode}), 64'd0);
    end

    // result backpressure with a competing request held valid
    res_ready = 1'b0;
    send(OP_SUB, 32'h0000_0003, 32'h0000_0005, 1'b0, 1'b0);
    instr_valid = 1'b1; instr_op = OP_ADD; instr_a = 32'd7; instr_b = 32'd9;
    repeat (6) begin
      @(negedge clk);
      check("busy_instr_ready", 64'({g_dut[0].instr_ready, g_dut[1].instr_ready}), 64'd0);
    end
    instr_valid = 1'b0;
    res_ready   = 1'b1;

    send(OP_EQ, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1'b0, 1'b0);

    // asynchronous reset while the LAT=3 instance is mid-EXEC
    send(OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    g_dut[0].exp_q.delete();
    g_dut[1].exp_q.delete();
    exp_cf = 1'b0;
    #1;
    check_reset_state("midrst");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_idle", 64'({g_dut[0].res_valid, g_dut[1].res_valid,
                                  g_dut[0].instr_ready, g_dut[1].instr_ready}), 64'b0011);
    end
    send(OP_ADD, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);

    // random traffic
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 3))
        0: rop = OP_ADD;
        1: rop = OP_SUB;
        2: rop = OP_EQ;
        default: begin
          rop = 6'($urandom_range(0, 63));
          if (rop == OP_ADD || rop == OP_SUB || rop == OP_EQ) rop = 6'b000000;
        end
      endcase
      if ($urandom_range(0, 3) == 0)
        send(rop, 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        send(rop, $urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    guard = 0;
    while ((g_dut[0].exp_q.size() != 0 || g_dut[1].exp_q.size() != 0) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("drain_q_L1", 64'(g_dut[0].exp_q.size()), 64'd0);
    check("drain_q_L3", 64'(g_dut[1].exp_q.size()), 64'd0);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $fatal(1);
  end

endmodule
